// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Loads a framed, big-endian byte stream into the instruction
//               memory write port and holds the CPU in reset while it loads.
//               Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int          MAX_WORDS = 512,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        write_enable,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic        busy,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CSUM   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_len;
   logic [15:0] r_idx;
   logic [31:0] r_word;
   logic [1:0]  r_bcnt;
   logic [31:0] r_addr;
   logic        w_accept;
   logic [15:0] w_len_full;
   logic [15:0] w_idx_next;
   logic [31:0] w_offset;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   assign w_accept      = byte_valid && byte_ready;
   assign w_len_full    = {r_len[15:8], byte_data};
   assign w_idx_next    = r_idx + 16'd1;
   assign w_offset      = {14'd0, r_idx, 2'b00};
   assign write_address = r_addr;
   assign write_data    = r_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      byte_ready   = 1'b0;
      write_enable = 1'b0;
      busy         = 1'b1;
      cpu_hold     = 1'b1;
      done         = 1'b0;
      error        = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy     = 1'b0;
            cpu_hold = 1'b0;
            if (start) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            byte_ready = 1'b1;
            if (w_accept) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready = 1'b1;
            if (w_accept) begin
               if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_next = S_CSUM;
`else
                  w_next = S_DONE;
`endif
               end else if ({1'b0, w_len_full} > c_max_words) begin
                  w_next = S_ERR;
               end else begin
                  w_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            write_enable = 1'b1;
            if (w_idx_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_next = S_CSUM;
`else
               w_next = S_DONE;
`endif
            end else begin
               w_next = S_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            byte_ready = 1'b1;
            if (w_accept) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            busy     = 1'b0;
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) w_next = S_LEN_HI;
         end
         S_ERR: begin
            busy  = 1'b0;
            error = 1'b1;
            if (start) w_next = S_LEN_HI;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address is captured with the last byte so it is stable during the strobe
   // and holds afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len  <= 16'd0;
         r_idx  <= 16'd0;
         r_word <= 32'd0;
         r_bcnt <= 2'd0;
         r_addr <= ADDR_BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum <= 8'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_len  <= 16'd0;
                  r_idx  <= 16'd0;
                  r_bcnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= 8'd0;
`endif
               end
            end
            S_LEN_HI: begin
               if (w_accept) r_len[15:8] <= byte_data;
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len[7:0] <= byte_data;
                  r_bcnt     <= 2'd0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_word <= {r_word[23:0], byte_data};
                  r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum + byte_data;
`endif
                  if (r_bcnt == 2'd3) r_addr <= ADDR_BASE + w_offset;
               end
            end
            S_WRITE: begin
               r_idx <= w_idx_next;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (table + random frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int MAXW = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        write_enable;
   logic [31:0] write_address;
   logic [31:0] write_data;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        error;

   imem_loader #(.MAX_WORDS(MAXW), .ADDR_BASE(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .busy(busy), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [63:0] wr_q[$];
   logic [63:0] exp_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  data_q[$];
   bit  exp_done;
   bit  exp_err;
   int  ready_in_write = 0;

   typedef struct {
      logic [15:0]      len;
      logic [2:0][31:0] w;
      bit               edone;
      bit               eerr;
      int               nwr;
   } vec_t;
   vec_t vecs[6];

   always @(negedge clk) begin
      if (write_enable) begin
         wr_q.push_back({write_address, write_data});
         if (byte_ready) ready_in_write++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      byte_data  = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         tests++;
         fails++;
         $display("FAIL byte_ready_timeout: got 0 expected 1");
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   // Reference model: frame bytes and expected writes from length + payload.
   task automatic build_frame(input logic [15:0] len, input bit bad_csum);
      logic [7:0] sum;
      sum = 8'h00;
      tx_q.delete();
      exp_q.delete();
      tx_q.push_back(len[15:8]);
      tx_q.push_back(len[7:0]);
      if (int'(len) > MAXW) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      for (int i = 0; i < int'(len) * 4; i++) begin
         tx_q.push_back(data_q[i]);
         sum = sum + data_q[i];
      end
      for (int w = 0; w < int'(len); w++)
         exp_q.push_back({32'(w * 4), data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]});
      exp_done = 1'b1;
      exp_err  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q.push_back(bad_csum ? sum + 8'd1 : sum);
      if (bad_csum) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
      end
`else
      if (bad_csum) sum = 8'h00;
`endif
   endtask

   task automatic run_frame(input int maxgap, input int start_at);
      int n;
      n = 0;
      wr_q.delete();
      ready_in_write = 0;
      pulse_start();
      check("busy_after_start", busy, 1'b1);
      check("hold_after_start", cpu_hold, 1'b1);
      for (int i = 0; i < tx_q.size(); i++) begin
         if (i == start_at) pulse_start();
         send_byte(tx_q[i], $urandom_range(maxgap, 0));
      end
      @(negedge clk);
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_result(input string tag);
      check({tag, "_done"}, done, exp_done);
      check({tag, "_error"}, error, exp_err);
      check({tag, "_cpu_hold"}, cpu_hold, exp_err);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
      check({tag, "_ready_in_write"}, ready_in_write, 0);
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         check({tag, "_write"}, wr_q[i], exp_q[i]);
   endtask

   task automatic fill_random(input int nwords);
      data_q.delete();
      for (int i = 0; i < nwords * 4; i++) data_q.push_back(8'($urandom));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{len: 16'h0001, w: {32'h0, 32'h0, 32'h2008_0005}, edone: 1'b1, eerr: 1'b0, nwr: 1};
      vecs[1] = '{len: 16'h0003, w: {32'h0800_0000, 32'h0109_5020, 32'h8C09_0000}, edone: 1'b1, eerr: 1'b0, nwr: 3};
      vecs[2] = '{len: 16'h0000, w: {32'h0, 32'h0, 32'h0}, edone: 1'b1, eerr: 1'b0, nwr: 0};
      vecs[3] = '{len: 16'h0201, w: {32'h0, 32'h0, 32'h0}, edone: 1'b0, eerr: 1'b1, nwr: 0};
      vecs[4] = '{len: 16'h0001, w: {32'h0, 32'h0, 32'h1234_5678}, edone: 1'b1, eerr: 1'b0, nwr: 1};
      vecs[5] = '{len: 16'h0002, w: {32'h0, 32'hCAFE_F00D, 32'hDEAD_BEEF}, edone: 1'b1, eerr: 1'b0, nwr: 2};

      // Reset state
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_hold", cpu_hold, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_ready", byte_ready, 1'b0);
      check("rst_we", write_enable, 1'b0);
      check("rst_addr", write_address, 32'h0);
      check("rst_data", write_data, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Table-driven frames
      for (int k = 0; k < 6; k++) begin
         data_q.delete();
         for (int w = 0; w < vecs[k].nwr; w++)
            for (int b = 3; b >= 0; b--) data_q.push_back(vecs[k].w[w][8*b +: 8]);
         build_frame(vecs[k].len, 1'b0);
         run_frame((k == 1) ? 5 : 2, -1);
         check("vec_done", done, vecs[k].edone);
         check("vec_error", error, vecs[k].eerr);
         check("vec_cpu_hold", cpu_hold, vecs[k].eerr);
         check("vec_busy", busy, 1'b0);
         check("vec_nwrites", wr_q.size(), vecs[k].nwr);
         check("vec_ready_in_write", ready_in_write, 0);
         for (int i = 0; i < wr_q.size() && i < vecs[k].nwr; i++) begin
            check("vec_addr", wr_q[i][63:32], 32'(i * 4));
            check("vec_data", wr_q[i][31:0], vecs[k].w[i]);
         end
      end

      // Random frames against the reference model
      for (int r = 0; r < 20; r++) begin
         int len;
         bit bad;
         len = $urandom_range(6, 0);
         bad = ($urandom_range(3, 0) == 0);
         fill_random(len);
         build_frame(16'(len), bad);
         run_frame(5, -1);
         check_result("rand");
      end

      // Largest accepted image, back-to-back bytes
      fill_random(MAXW);
      build_frame(16'(MAXW), 1'b0);
      run_frame(0, -1);
      check_result("maxlen");
      check("maxlen_addr_hold", write_address, 32'((MAXW - 1) * 4));

      // Bytes offered while DONE are neither accepted nor written
      @(negedge clk); byte_valid = 1'b1; byte_data = 8'hA5;
      repeat (4) begin
         @(negedge clk);
         check("idle_ready", byte_ready, 1'b0);
      end
      byte_valid = 1'b0;
      check("idle_nwrites", wr_q.size(), MAXW);
      check("idle_done", done, 1'b1);

      // Start while busy is ignored
      fill_random(2);
      build_frame(16'd2, 1'b0);
      run_frame(1, 5);
      check_result("start_busy");

      // Asynchronous reset mid-load after 6 of 12 data bytes
      fill_random(3);
      build_frame(16'd3, 1'b0);
      wr_q.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(tx_q[i], 0);
      @(negedge clk);
      check("midrst_pre_writes", wr_q.size(), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_hold", cpu_hold, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_error", error, 1'b0);
      check("midrst_ready", byte_ready, 1'b0);
      check("midrst_we", write_enable, 1'b0);
      check("midrst_addr", write_address, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      fill_random(3);
      build_frame(16'd3, 1'b0);
      run_frame(2, -1);
      check_result("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
      data_q.delete();
      data_q.push_back(8'h12); data_q.push_back(8'h34);
      data_q.push_back(8'h56); data_q.push_back(8'h78);
      build_frame(16'd1, 1'b0);
      run_frame(1, -1);
      check("csum_ok_done", done, 1'b1);
      check("csum_ok_nwrites", wr_q.size(), 1);
      build_frame(16'd1, 1'b1);
      run_frame(1, -1);
      check("csum_bad_error", error, 1'b1);
      check("csum_bad_hold", cpu_hold, 1'b1);
      check("csum_bad_nwrites", wr_q.size(), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
